hazard_stall_ctrl: RTL
======================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter MD_TIMEOUT, default 64, meaning maximum MD_BUSY cycles before timeout (range 2..255).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserted (0) forces reset state immediately, independent of clk.
REQ-004 ID_RegRs, ID_RegRt  input  5 each  source register numbers of the instruction in ID.
REQ-005 ID_UsesRt  input  1  ID instruction reads Rt (R-type, branch, store).
REQ-006 ID_Branch  input  1  ID instruction is a branch resolved in ID.
REQ-007 ID_BranchTaken  input  1  branch/jump in ID resolved taken this cycle.
REQ-008 ID_MulDiv  input  1  ID instruction is a multi-cycle multiply/divide.
REQ-009 EX_MemRead, EX_RegWrite  input  1 each  control bits leaving the ID/EX register.
REQ-010 EX_RegWrAddr  input  5  destination register of the EX instruction.
REQ-011 MEM_MemRead  input  1  load in MEM stage; MEM_RegWrAddr  input  5  its destination.
REQ-012 md_done  input  1  one-cycle pulse from the mul/div unit on completion.
REQ-013 stall_IF_ID  output  1  bubble into ID/EX this cycle.
REQ-014 PC_Write, IF_ID_Write  output  1 each  enables for PC and IF/ID (low = hold).
REQ-015 flush_IF_ID  output  1  clear IF/ID at next edge.
REQ-016 md_start  output  1  one-cycle start pulse to mul/div unit; md_timeout  output  1  sticky error.

Function
REQ-017 Register 0 never creates a hazard; all comparisons below require address != 0.
REQ-018 Load-use hazard (lu) SHALL be EX_MemRead and EX_RegWrAddr equal to ID_RegRs, or to ID_RegRt with ID_UsesRt.
REQ-019 Branch hazard (bh) SHALL be ID_Branch with a source match against EX_RegWrAddr (EX_RegWrite) or MEM_RegWrAddr (MEM_MemRead).
REQ-020 Hazard detection SHALL be combinational in the same cycle: stall_IF_ID=1, PC_Write=0, IF_ID_Write=0 while lu, bh or state != IDLE.
REQ-021 Branch on EX load SHALL thus stall 2 cycles, on EX ALU result or MEM load 1 cycle, on load-use 1 cycle.
REQ-022 FSM states IDLE, MD_BUSY, MD_DRAIN; IDLE->MD_BUSY when ID_MulDiv and no lu/bh, with md_start=1 for that cycle only.
REQ-023 MD_BUSY: stall asserted; 8-bit counter increments each cycle; md_done -> MD_DRAIN; counter reaching MD_TIMEOUT-1 without md_done -> set md_timeout, go MD_DRAIN.
REQ-024 MD_DRAIN: stall asserted one cycle, then IDLE, counter cleared; md_done in MD_DRAIN or IDLE ignored.
REQ-025 In MD_BUSY, md_done and timeout in the same cycle: md_done wins, md_timeout not set.
REQ-026 flush_IF_ID SHALL equal ID_BranchTaken and not stall_IF_ID; a taken branch under stall flushes only in its unstalled cycle.
REQ-027 md_timeout remains 1 until reset.

Reset
REQ-028 Reset asserted: state=IDLE, counter=0, md_timeout=0, md_start=0, perf counters=0; combinational outputs follow inputs with state IDLE.
REQ-029 Reset mid MD_BUSY SHALL abandon the operation; no md_start re-issue until a new ID_MulDiv.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN defined: outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], counting cycles with stall_IF_ID=1 and flush_IF_ID=1, saturating at 0xFFFFFFFF, cleared by reset.
REQ-031 Macro undefined: both ports and counters absent; all other behaviour identical.

Verification
REQ-032 EX lw $8 (EX_MemRead=1, EX_RegWrAddr=8), ID add rs=8 -> stall_IF_ID=1, PC_Write=0 one cycle, then 0.
REQ-033 EX lw $0, ID rs=0 -> stall_IF_ID=0.
REQ-034 ID beq rs=9 with EX lw $9 -> 2 consecutive stall cycles; ID_BranchTaken then -> flush_IF_ID=1 only in the third cycle.
REQ-035 ID_MulDiv=1, md_done after 5 cycles -> md_start one pulse, stall for 5+1 (MD_DRAIN) cycles, md_timeout=0.
REQ-036 MD_TIMEOUT=4, md_done never -> md_timeout=1 after 4 MD_BUSY cycles, return to IDLE after drain, remains 1.
REQ-037 reset=0 asynchronously in MD_BUSY -> state IDLE and stall_IF_ID=0 before next clk edge; with HAZARD_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Purpose:
//   Hazard detection and stall/flush control for the ID stage of a
//   5-stage pipeline. It detects load-use and branch-operand hazards
//   combinationally. It also sequences a multi-cycle multiply/divide unit
//   and holds the front end stalled while that unit is busy.
//
// Parameters:
//   MD_TIMEOUT      maximum MD_BUSY cycles before a timeout (2..255)
//
// Ports:
//   clk             single clock, rising edge
//   reset           asynchronous, active-low
//   ID_RegRs/Rt     source registers of the ID instruction
//   ID_UsesRt       ID instruction reads Rt
//   ID_Branch       ID instruction is a branch resolved in ID
//   ID_BranchTaken  branch/jump in ID resolved taken this cycle
//   ID_MulDiv       ID instruction is a multi-cycle mul/div
//   EX_MemRead      EX instruction is a load
//   EX_RegWrite     EX instruction writes a register
//   EX_RegWrAddr    destination register of the EX instruction
//   MEM_MemRead     MEM instruction is a load
//   MEM_RegWrAddr   destination register of the MEM instruction
//   md_done         completion pulse from the mul/div unit
//   stall_IF_ID     bubble into ID/EX
//   PC_Write        PC enable (low = hold)
//   IF_ID_Write     IF/ID enable (low = hold)
//   flush_IF_ID     clear IF/ID at the next edge
//   md_start        one-cycle start pulse to the mul/div unit
//   md_timeout      sticky mul/div timeout flag
//   perf_stall_cnt  saturating count of stall cycles  (HAZARD_PERF_CNT_EN)
//   perf_flush_cnt  saturating count of flush cycles  (HAZARD_PERF_CNT_EN)
//
// Build option:
//   HAZARD_PERF_CNT_EN  when defined, adds the two performance counters.
//
// States:
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no mul/div in flight; stall only on lu/bh hazards
//   MD_BUSY  | mul/div running; stall, count cycles, watch for timeout
//   MD_DRAIN | one stall cycle after completion/timeout, then IDLE
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_RegRs,
    input  logic [4:0]  ID_RegRt,
    input  logic        ID_UsesRt,
    input  logic        ID_Branch,
    input  logic        ID_BranchTaken,
    input  logic        ID_MulDiv,
    input  logic        EX_MemRead,
    input  logic        EX_RegWrite,
    input  logic [4:0]  EX_RegWrAddr,
    input  logic        MEM_MemRead,
    input  logic [4:0]  MEM_RegWrAddr,
    input  logic        md_done,
    output logic        stall_IF_ID,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        flush_IF_ID,
    output logic        md_start,
    output logic        md_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MD_BUSY  = 2'd1,
        MD_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(MD_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] md_cnt;

    logic ex_rs_match;
    logic ex_rt_match;
    logic mem_rs_match;
    logic mem_rt_match;
    logic lu;
    logic bh;
    logic timeout_hit;
    logic timeout_set;

    // Register 0 is hardwired, so a zero source never matches anything.
    always_comb begin
        ex_rs_match  = (ID_RegRs != 5'd0) && (EX_RegWrAddr == ID_RegRs);
        ex_rt_match  = ID_UsesRt && (ID_RegRt != 5'd0) && (EX_RegWrAddr == ID_RegRt);
        mem_rs_match = (ID_RegRs != 5'd0) && (MEM_RegWrAddr == ID_RegRs);
        mem_rt_match = ID_UsesRt && (ID_RegRt != 5'd0) && (MEM_RegWrAddr == ID_RegRt);

        lu = EX_MemRead && (ex_rs_match || ex_rt_match);

        // The branch compares in ID, so it needs the value one stage earlier
        // than an ALU consumer would: an EX producer or a MEM load blocks it.
        bh = ID_Branch &&
             ((EX_RegWrite && (ex_rs_match || ex_rt_match)) ||
              (MEM_MemRead && (mem_rs_match || mem_rt_match)));

        timeout_hit = (md_cnt == TO_LAST);
        // md_done takes priority over a timeout in the same cycle.
        timeout_set = (state == MD_BUSY) && timeout_hit && !md_done;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ID_MulDiv && !lu && !bh) begin
                    state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (md_done || timeout_hit) begin
                    state_nxt = MD_DRAIN;
                end
            end
            MD_DRAIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        stall_IF_ID = lu || bh || (state != IDLE);
        PC_Write    = !stall_IF_ID;
        IF_ID_Write = !stall_IF_ID;
        flush_IF_ID = ID_BranchTaken && !stall_IF_ID;
        // Gated by reset so no start pulse escapes while reset is held.
        md_start    = reset && (state == IDLE) && ID_MulDiv && !lu && !bh;
    end

    // Busy-cycle counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt     <= 8'd0;
            md_timeout <= 1'b0;
        end else begin
            if ((state == MD_BUSY) && (state_nxt == MD_BUSY)) begin
                md_cnt <= md_cnt + 8'd1;
            end else begin
                md_cnt <= 8'd0;
            end
            if (timeout_set) begin
                md_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (stall_IF_ID && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (flush_IF_ID && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
